pixel_readout_encoder: RTL and testbench
========================================

// Module: pixel_readout_encoder
// PURPOSE
//  Sequential, parametrised priority encoder for the pixel readout chain. It captures
//  hit flags from N_PIX pixels into sticky registers and presents one pending pixel
//  address at a time. Each address is handed over with a valid/read handshake, after
//  which the block pulses that pixel's reset line. It sits between the pixel array
//  state outputs and the column/periphery readout logic.
// PARAMETERS
//  N_PIX       8  number of pixel inputs (>=2)
//  AW          $clog2(N_PIX)  address width (derived, do not override)
//  ROUND_ROBIN 0  0: fixed priority, highest index wins; 1: rotating priority from last served+1
//  CLR_CYCLES  1  width of per-pixel reset pulse in clocks (1..15)
// PORTS
//  clk             in   1      clock
//  reset_encoder_n in   1      synchronous reset, active low
//  state           in   N_PIX  pixel hit flags (level)
//  mask            in   N_PIX  1 = pixel disabled: never captured, never served
//  read            in   1      consumer accepts addr while valid=1
//  addr            out  AW     address of presented/served pixel (registered)
//  valid           out  1      addr holds a pending hit (registered)
//  reset           out  N_PIX  one-hot per-pixel reset pulse (registered)
//  hit_count       out  AW+1   number of pending captured hits (registered)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low. All registers update on posedge clk.
//  - Reset (reset_encoder_n=0 at an edge): hit_q=0, FSM=IDLE, valid=0, addr=all ones,
//    reset=0, hit_count=0, rr pointer=N_PIX-1. Reset overrides everything, including mid-CLEAR.
//  - Capture: every cycle, hit_q <= (hit_q | (state & ~mask & ~clr_mask)) & ~served.
//    clr_mask is the one-hot of addr while FSM=CLEAR; otherwise clr_mask=0.
//    served is the one-hot of addr on the cycle PRESENT exits with read=1; otherwise served=0.
//    A hit captured at edge t is visible to the FSM at edge t+1, so valid rises two edges after state.
//  - Masking a bit also clears the corresponding hit_q bit on the next edge.
//  - Winner select (combinational on hit_q):
//    ROUND_ROBIN=0: highest set index wins.
//    ROUND_ROBIN=1: first set bit scanning upward from rr+1, wrapping modulo N_PIX.
//  - FSM:
//    IDLE:    valid=0, addr holds its last value. If hit_q!=0: addr<=winner, valid<=1, go to PRESENT.
//    PRESENT: addr and valid are stable. read=1 -> valid<=0, hit_q[addr] cleared, rr<=addr,
//             reset<=onehot(addr), cnt<=CLR_CYCLES-1, go to CLEAR. read=0 -> hold.
//    CLEAR:   reset stays onehot(addr) for exactly CLR_CYCLES cycles; state[addr] is ignored.
//             At cnt==0: reset<=0; if hit_q (excluding addr) != 0, load the next winner and set
//             valid<=1 (go to PRESENT), else go to IDLE.
//  - read while valid=0 is ignored. Holding read=1 continuously gives one hit per CLR_CYCLES+1 clocks.
//  - If the presented pixel is masked during PRESENT, the FSM drops valid and returns to IDLE
//    on the next edge. No reset pulse is issued.
//  - hit_count <= popcount of the next hit_q value. It saturates naturally at N_PIX.
//  - At most one reset bit is high at any time. addr never points at a masked pixel while valid=1.
// TESTING
//  1 Reset: drive reset_encoder_n=0 with state=8'hFF -> valid=0, addr=3'b111, reset=0, hit_count=0.
//  2 Fixed priority: state=8'b1001_0010 for one cycle, read=1 held -> addrs 7, 4, 1 in order.
//    Each is followed by a reset pulse of CLR_CYCLES on that bit; then valid=0, hit_count=0.
//  3 Rotating (ROUND_ROBIN=1): serve 4, then re-hit pixels 7 and 2 -> order 7, 2.
//    Next hit on pixels 0 and 5 -> order 5, 0.
//  4 Re-hit during clear (CLR_CYCLES=3): state[3] held high through the CLEAR of pixel 3.
//    -> no recapture while reset[3]=1. Recapture occurs if state[3] is still high after the pulse.
//  5 Backpressure/mask: read=0 for 10 cycles -> addr and valid stable.
//    Then set mask of the presented pixel -> valid falls on the next edge, no reset pulse,
//    next winner presented.
//  6 Mid-operation reset: assert reset_encoder_n=0 during CLEAR -> reset=0 on the next edge,
//    all pending hits are dropped.

Source files
------------

// File: rtl/pixel_readout_encoder_if.sv
// Pixel readout encoder bus: hit/mask inputs, read handshake,
// presented address, per-pixel reset pulses and pending-hit count.
interface pixel_readout_encoder_if #(
  parameter int N_PIX = 8
);
  localparam int AW = $clog2(N_PIX);

  logic [N_PIX-1:0] state;
  logic [N_PIX-1:0] mask;
  logic             read;
  logic [AW-1:0]    addr;
  logic             valid;
  logic [N_PIX-1:0] reset;
  logic [AW:0]      hit_count;

  modport master (
    output state, mask, read,
    input  addr, valid, reset, hit_count
  );

  modport slave (
    input  state, mask, read,
    output addr, valid, reset, hit_count
  );
endinterface

// File: rtl/pixel_readout_encoder.sv
// Sticky-hit priority encoder: captures pixel hits, presents one
// address at a time and pulses that pixel's reset after each read.
module pixel_readout_encoder #(
  parameter int N_PIX       = 8,
  parameter int ROUND_ROBIN = 0,
  parameter int CLR_CYCLES  = 1
) (
  input logic clk,
  input logic reset_encoder_n,
  pixel_readout_encoder_if.slave bus
);
  localparam int AW = $clog2(N_PIX);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    CLEAR
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [N_PIX-1:0] hit_q, hit_d;
  logic [N_PIX-1:0] reset_q, reset_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    rr_q, rr_d;
  logic             valid_q, valid_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW:0]      hit_count_q, hit_count_d;

  logic [N_PIX-1:0] addr_oh;
  logic [N_PIX-1:0] clr_mask;
  logic [N_PIX-1:0] served;
  logic [N_PIX-1:0] cand;
  logic [N_PIX-1:0] cand_ex;
  logic [AW-1:0]    win;
  logic [AW-1:0]    win_ex;
  logic             drop;
  logic             take;

  // Rotate so the scan starts at rr+1, then take the first (rotating)
  // or last (fixed, highest index) set bit and undo the rotation.
  function automatic logic [AW-1:0] pick(
    input logic [N_PIX-1:0] v,
    input logic [AW-1:0]    rr
  );
    logic [N_PIX-1:0] r;
    logic             found;
    int               sh;
    int               k;
    sh = (int'(rr) + 1 >= N_PIX) ? 0 : int'(rr) + 1;
    if (ROUND_ROBIN == 0) sh = 0;
    r = N_PIX'({v, v} >> sh);
    k = 0;
    found = 1'b0;
    for (int i = 0; i < N_PIX; i++) begin
      if (r[0]) begin
        if (ROUND_ROBIN == 0) begin
          k = i;
        end else if (!found) begin
          k = i;
          found = 1'b1;
        end
      end
      r = r >> 1;
    end
    k = k + sh;
    if (k >= N_PIX) k = k - N_PIX;
    return AW'(k);
  endfunction

  function automatic logic [AW:0] popcnt(
    input logic [N_PIX-1:0] v
  );
    logic [N_PIX-1:0] t;
    logic [AW:0]      c;
    t = v;
    c = '0;
    for (int i = 0; i < N_PIX; i++) begin
      c = c + (AW+1)'(t[0]);
      t = t >> 1;
    end
    return c;
  endfunction

  assign addr_oh  = N_PIX'(1) << addr_q;
  assign drop     = (fsm_q == PRESENT) && bus.mask[addr_q];
  assign take     = (fsm_q == PRESENT) && !drop && bus.read;
  assign clr_mask = (fsm_q == CLEAR) ? addr_oh : '0;
  assign served   = take ? addr_oh : '0;
  assign cand     = hit_q & ~bus.mask;
  assign cand_ex  = cand & ~addr_oh;
  assign win      = pick(cand, rr_q);
  assign win_ex   = pick(cand_ex, rr_q);

  // Sticky hit capture; the pixel being cleared and masked pixels are ignored.
  always_comb begin
    hit_d = (hit_q | (bus.state & ~bus.mask & ~clr_mask))
          & ~served & ~bus.mask;
    hit_count_d = popcnt(hit_d);
  end

  // Serve sequence: present a winner, wait for read, pulse its reset.
  always_comb begin
    fsm_d   = fsm_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    reset_d = reset_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    unique case (fsm_q)
      IDLE: begin
        valid_d = 1'b0;
        if (|cand) begin
          addr_d  = win;
          valid_d = 1'b1;
          fsm_d   = PRESENT;
        end
      end
      PRESENT: begin
        if (drop) begin
          valid_d = 1'b0;
          fsm_d   = IDLE;
        end else if (take) begin
          valid_d = 1'b0;
          rr_d    = addr_q;
          reset_d = addr_oh;
          cnt_d   = 4'(CLR_CYCLES - 1);
          fsm_d   = CLEAR;
        end
      end
      CLEAR: begin
        if (cnt_q == '0) begin
          reset_d = '0;
          if (|cand_ex) begin
            addr_d  = win_ex;
            valid_d = 1'b1;
            fsm_d   = PRESENT;
          end else begin
            fsm_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        valid_d = 1'b0;
        reset_d = '0;
        fsm_d   = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_encoder_n) begin
      fsm_q       <= IDLE;
      hit_q       <= '0;
      addr_q      <= '1;
      valid_q     <= 1'b0;
      reset_q     <= '0;
      cnt_q       <= '0;
      rr_q        <= AW'(N_PIX - 1);
      hit_count_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      hit_q       <= hit_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      reset_q     <= reset_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign bus.addr      = addr_q;
  assign bus.valid     = valid_q;
  assign bus.reset     = reset_q;
  assign bus.hit_count = hit_count_q;
endmodule

// File: tb/tb_pixel_readout_encoder.sv
// Bench for pixel_readout_encoder: fixed-priority (CLR=3) and
// rotating-priority (CLR=1) instances with a handshake scoreboard.
module tb_pixel_readout_encoder;
  localparam int N      = 8;
  localparam int FP_CLR = 3;
  localparam int RR_CLR = 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   fp_q[$];
  int   rr_q[$];
  int   plen[2] = '{0, 0};
  logic ppend[2] = '{1'b0, 1'b0};
  logic [N-1:0] pexp[2] = '{8'h00, 8'h00};

  pixel_readout_encoder_if #(.N_PIX(N)) fp_if ();
  pixel_readout_encoder_if #(.N_PIX(N)) rr_if ();

  pixel_readout_encoder #(
    .N_PIX(N), .ROUND_ROBIN(0), .CLR_CYCLES(FP_CLR)
  ) u_fp (
    .clk(clk), .reset_encoder_n(rst_n), .bus(fp_if.slave)
  );

  pixel_readout_encoder #(
    .N_PIX(N), .ROUND_ROBIN(1), .CLR_CYCLES(RR_CLR)
  ) u_rr (
    .clk(clk), .reset_encoder_n(rst_n), .bus(rr_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pulse tracking first, then handshake pop.
  task automatic mon(input int k, input logic v, input logic rd,
                     input logic [N-1:0] m, input logic [2:0] a,
                     input logic [N-1:0] rs);
    int clr;
    int e;
    bit ok;
    clr = (k == 0) ? FP_CLR : RR_CLR;
    if (!rst_n) begin
      plen[k]  = 0;
      ppend[k] = 1'b0;
      return;
    end
    if (rs != '0) begin
      check($sformatf("pulse_bits_dut%0d", k), int'(rs),
            ppend[k] ? int'(pexp[k]) : 0);
      plen[k]++;
    end else if (plen[k] > 0) begin
      check($sformatf("pulse_width_dut%0d", k), plen[k], clr);
      plen[k]  = 0;
      ppend[k] = 1'b0;
    end
    if (v && rd && !m[a]) begin
      ok = 1'b0;
      e  = 0;
      if (k == 0 && fp_q.size() > 0) begin
        e = fp_q.pop_front();
        ok = 1'b1;
      end else if (k == 1 && rr_q.size() > 0) begin
        e = rr_q.pop_front();
        ok = 1'b1;
      end
      if (!ok) begin
        check($sformatf("unexpected_addr_dut%0d", k), int'(a), -1);
      end else begin
        check($sformatf("addr_dut%0d", k), int'(a), e);
        ppend[k] = 1'b1;
        pexp[k]  = N'(1) << e;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, fp_if.valid, fp_if.read, fp_if.mask, fp_if.addr, fp_if.reset);
    mon(1, rr_if.valid, rr_if.read, rr_if.mask, rr_if.addr, rr_if.reset);
  end

  task automatic drain(input int k, input int maxc);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < maxc) begin
      tick();
      n++;
      if (k == 0)
        done = fp_q.size() == 0 && !fp_if.valid && fp_if.reset == '0;
      else
        done = rr_q.size() == 0 && !rr_if.valid && rr_if.reset == '0;
    end
    check($sformatf("drain_dut%0d", k), int'(done), 1);
    repeat (2) tick();
  endtask

  task automatic rr_burst(input logic [N-1:0] s, input int a0,
                          input int a1, input bit two);
    rr_q.push_back(a0);
    if (two) rr_q.push_back(a1);
    rr_if.state = s;
    tick();
    rr_if.state = '0;
    drain(1, 20);
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    fp_if.state = 8'hFF;
    fp_if.mask  = '0;
    fp_if.read  = 1'b0;
    rr_if.state = 8'hFF;
    rr_if.mask  = '0;
    rr_if.read  = 1'b0;
    repeat (3) tick();

    check("rst_fp_valid", int'(fp_if.valid), 0);
    check("rst_fp_addr", int'(fp_if.addr), 7);
    check("rst_fp_reset", int'(fp_if.reset), 0);
    check("rst_fp_hitcnt", int'(fp_if.hit_count), 0);
    check("rst_rr_valid", int'(rr_if.valid), 0);
    check("rst_rr_addr", int'(rr_if.addr), 7);
    check("rst_rr_reset", int'(rr_if.reset), 0);
    check("rst_rr_hitcnt", int'(rr_if.hit_count), 0);

    fp_if.state = '0;
    rr_if.state = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // fixed priority: 7, 4, 1
    fp_if.read = 1'b1;
    fp_q.push_back(7);
    fp_q.push_back(4);
    fp_q.push_back(1);
    fp_if.state = 8'b1001_0010;
    tick();
    fp_if.state = '0;
    check("fp_hitcnt_capture", int'(fp_if.hit_count), 3);
    drain(0, 40);
    check("fp_end_valid", int'(fp_if.valid), 0);
    check("fp_end_hitcnt", int'(fp_if.hit_count), 0);

    // rotating priority
    rr_if.read = 1'b1;
    rr_burst(8'h10, 4, 0, 1'b0);
    rr_burst(8'h84, 7, 2, 1'b1);
    rr_burst(8'h21, 5, 0, 1'b1);
    rr_burst(8'h42, 1, 6, 1'b1);
    check("rr_end_hitcnt", int'(rr_if.hit_count), 0);

    // re-hit during clear
    fp_q.push_back(3);
    fp_if.state = 8'h08;
    n = 0;
    while (fp_if.reset[3] == 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("clr_pulse_seen", int'(fp_if.reset[3]), 1);
    while (fp_if.reset != '0 && n < 40) begin
      check("no_recapture_in_clear", int'(fp_if.hit_count), 0);
      tick();
      n++;
    end
    fp_q.push_back(3);
    tick();
    fp_if.state = '0;
    check("recapture_after_clear", int'(fp_if.hit_count), 1);
    drain(0, 40);

    // backpressure then mask
    fp_if.read  = 1'b0;
    fp_if.state = 8'h60;
    tick();
    fp_if.state = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", int'(fp_if.valid), 1);
      check("bp_addr", int'(fp_if.addr), 6);
      tick();
    end
    check("bp_hitcnt", int'(fp_if.hit_count), 2);
    fp_if.mask = 8'h40;
    tick();
    check("mask_valid_drop", int'(fp_if.valid), 0);
    check("mask_no_pulse", int'(fp_if.reset), 0);
    tick();
    check("mask_next_valid", int'(fp_if.valid), 1);
    check("mask_next_addr", int'(fp_if.addr), 5);
    fp_q.push_back(5);
    fp_if.read = 1'b1;
    drain(0, 20);
    fp_if.mask = '0;

    // reset during clear
    fp_q.push_back(6);
    fp_if.state = 8'h44;
    tick();
    fp_if.state = '0;
    n = 0;
    while (fp_if.reset == '0 && n < 20) begin
      tick();
      n++;
    end
    check("mid_rst_pulse_seen", int'(fp_if.reset), 32'h40);
    rst_n = 1'b0;
    tick();
    check("mid_rst_reset", int'(fp_if.reset), 0);
    check("mid_rst_valid", int'(fp_if.valid), 0);
    check("mid_rst_hitcnt", int'(fp_if.hit_count), 0);
    check("mid_rst_addr", int'(fp_if.addr), 7);
    rst_n = 1'b1;
    repeat (5) tick();
    check("mid_rst_dropped_valid", int'(fp_if.valid), 0);
    check("mid_rst_dropped_hitcnt", int'(fp_if.hit_count), 0);

    check("fp_queue_empty", fp_q.size(), 0);
    check("rr_queue_empty", rr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
